servo_ramp_gen: RTL

SERVO_RAMP_GEN -- requirements
Module: servo_ramp_gen

---
 rtl/servo_pkg.sv | 46 ++++
 rtl/servo_frame_timer.sv | 32 +++
 rtl/servo_ramp_gen.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared definitions for the servo ramp generator: register map, STATUS bit
// positions, controller state encoding and the ramp step rule.
package servo_pkg;

  localparam int FRAME_CYCLES_DEFAULT = 2000000;

  // Register word offsets, decoded from s_adr[4:2]
  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_TARGET  = 3'd1;
  localparam logic [2:0] REG_STEP    = 3'd2;
  localparam logic [2:0] REG_CURRENT = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;

  // CTRL bit positions
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;

  // STATUS bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_UPDATE = 2'd2
  } servo_state_e;

  // One ramp step from cur toward tgt; never overshoots, STEP=0 jumps straight.
  function automatic logic [31:0] ramp_next(input logic [31:0] cur,
                                            input logic [31:0] tgt,
                                            input logic [31:0] step);
    logic        up;
    logic [31:0] diff;
    up   = (tgt >= cur);
    diff = up ? (tgt - cur) : (cur - tgt);
    if ((step == 32'd0) || (diff <= step)) begin
      return tgt;
    end else if (up) begin
      return cur + step;
    end else begin
      return cur - step;
    end
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Frame timer: counts 0..FRAME_CYCLES-1 and flags the wrap cycle as a tick.
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             wrap;

  assign wrap   = (cnt_q == CNT_LAST);
  assign cnt_d  = wrap ? '0 : cnt_q + 1'b1;
  assign tick_o = wrap;

  // Free-running frame counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/servo_ramp_gen.sv
// Servo ramp generator: a register slave configures a target/step, and on each
// frame tick the controller writes the next ramp position to a servo through
// the master port, with ack timeout, done/timeout flags and a level interrupt.
module servo_ramp_gen
  import servo_pkg::*;
#(
  parameter int          FRAME_CYCLES = FRAME_CYCLES_DEFAULT,
  parameter logic [31:0] SERVO_ADR    = 32'h0000_0004,
  parameter int          ACK_TIMEOUT  = 16
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        s_cyc,
  input  logic        s_stb,
  input  logic        s_we,
  input  logic [31:0] s_adr,
  input  logic [31:0] s_dat_i,
  output logic        s_ack,
  output logic [31:0] s_dat_o,
  output logic        m_cyc,
  output logic        m_stb,
  output logic        m_we,
  output logic [3:0]  m_sel,
  output logic [31:0] m_adr,
  output logic [31:0] m_dat_o,
  input  logic        m_ack,
  output logic        busy,
  output logic        irq
);

  localparam int WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  // Reset: asserted asynchronously, released two edges after wb_rst_n rises
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  // Two-flop deassertion synchroniser
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  // Frame tick
  logic tick;

  servo_frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_frame_timer (
    .clk_i (wb_clk),
    .rst_ni(rst_n_int),
    .tick_o(tick)
  );

  // Register file and slave port state
  logic        enable_q,  enable_d;
  logic        irq_en_q,  irq_en_d;
  logic [31:0] target_q,  target_d;
  logic [31:0] step_q,    step_d;
  logic [31:0] current_q, current_d;
  logic        done_q,    done_d;
  logic        timeout_q, timeout_d;
  logic        s_ack_q,   s_ack_d;
  logic [31:0] s_dat_q,   s_dat_d;

  // Controller state
  servo_state_e      state_q;
  logic [31:0]       next_q;
  logic [WAIT_W-1:0] wait_q;
  logic              m_cyc_q, m_stb_q, m_we_q;
  logic [3:0]        m_sel_q;
  logic [31:0]       m_adr_q, m_dat_q;

  logic        req;
  logic        wr;
  logic [2:0]  reg_idx;
  logic [31:0] rd_data;
  logic [31:0] next_val;
  logic        start;
  logic        upd_evt;
  logic        tmo_evt;
  logic        unused_adr_bits;

  assign unused_adr_bits = ^{s_adr[31:5], s_adr[1:0]};

  assign req     = s_cyc & s_stb & ~s_ack_q;
  assign wr      = req & s_we;
  assign reg_idx = s_adr[4:2];

  assign next_val = ramp_next(current_q, target_q, step_q);
  assign start    = tick & enable_q & (current_q != target_q);
  assign upd_evt  = (state_q == ST_UPDATE);
  assign tmo_evt  = (state_q == ST_WRITE) & ~m_ack & (wait_q == WAIT_LAST);

  // Read data multiplexer over the register map
  always_comb begin
    rd_data = '0;
    case (reg_idx)
      REG_CTRL: begin
        rd_data[CTRL_ENABLE] = enable_q;
        rd_data[CTRL_IRQ_EN] = irq_en_q;
      end
      REG_TARGET:  rd_data = target_q;
      REG_STEP:    rd_data = step_q;
      REG_CURRENT: rd_data = current_q;
      REG_STATUS: begin
        rd_data[STAT_BUSY]    = busy;
        rd_data[STAT_DONE]    = done_q;
        rd_data[STAT_TIMEOUT] = timeout_q;
      end
      default: rd_data = '0;
    endcase
  end

  // Next-state of the register file: bus writes first, controller sets last
  // so a set beats a same-cycle W1C clear
  always_comb begin
    enable_d  = enable_q;
    irq_en_d  = irq_en_q;
    target_d  = target_q;
    step_d    = step_q;
    current_d = current_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    s_ack_d   = req;
    s_dat_d   = req ? rd_data : s_dat_q;

    if (wr) begin
      case (reg_idx)
        REG_CTRL: begin
          enable_d = s_dat_i[CTRL_ENABLE];
          irq_en_d = s_dat_i[CTRL_IRQ_EN];
        end
        REG_TARGET: target_d = s_dat_i;
        REG_STEP:   step_d   = s_dat_i;
        REG_STATUS: begin
          if (s_dat_i[STAT_DONE])    done_d    = 1'b0;
          if (s_dat_i[STAT_TIMEOUT]) timeout_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (upd_evt) begin
      current_d = next_q;
      if (next_q == target_q) done_d = 1'b1;
    end
    if (tmo_evt) timeout_d = 1'b1;
  end

  // Register file and slave response registers
  always_ff @(posedge wb_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      enable_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      target_q  <= '0;
      step_q    <= '0;
      current_q <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      s_ack_q   <= 1'b0;
      s_dat_q   <= '0;
    end else begin
      enable_q  <= enable_d;
      irq_en_q  <= irq_en_d;
      target_q  <= target_d;
      step_q    <= step_d;
      current_q <= current_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      s_ack_q   <= s_ack_d;
      s_dat_q   <= s_dat_d;
    end
  end

  // Controller FSM with registered master outputs; NEXT is frozen on entry
  always_ff @(posedge wb_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= ST_IDLE;
      next_q  <= '0;
      wait_q  <= '0;
      m_cyc_q <= 1'b0;
      m_stb_q <= 1'b0;
      m_we_q  <= 1'b0;
      m_sel_q <= 4'h0;
      m_adr_q <= '0;
      m_dat_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_WRITE;
            next_q  <= next_val;
            wait_q  <= '0;
            m_cyc_q <= 1'b1;
            m_stb_q <= 1'b1;
            m_we_q  <= 1'b1;
            m_sel_q <= 4'hF;
            m_adr_q <= SERVO_ADR;
            m_dat_q <= next_val;
          end
        end
        ST_WRITE: begin
          if (m_ack || (wait_q == WAIT_LAST)) begin
            state_q <= m_ack ? ST_UPDATE : ST_IDLE;
            m_cyc_q <= 1'b0;
            m_stb_q <= 1'b0;
            m_we_q  <= 1'b0;
            m_sel_q <= 4'h0;
            m_adr_q <= '0;
            m_dat_q <= '0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ST_UPDATE: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ack   = s_ack_q;
  assign s_dat_o = s_dat_q;
  assign m_cyc   = m_cyc_q;
  assign m_stb   = m_stb_q;
  assign m_we    = m_we_q;
  assign m_sel   = m_sel_q;
  assign m_adr   = m_adr_q;
  assign m_dat_o = m_dat_q;
  assign busy    = (state_q == ST_WRITE);
  assign irq     = irq_en_q & (done_q | timeout_q);

endmodule
